// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at launch, held in pending registers, and committed after a fixed latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  state_t      state, state_d;
  logic [4:0]  cnt, cnt_d;
  logic [31:0] p_hi, p_hi_d, p_lo, p_lo_d, hi_d, lo_d;
  logic        p_vld, p_vld_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den_s, den_u, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_nz;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes; min/-1 naturally wraps to 0x80000000.
  assign b_nz  = (B != 32'd0);
  assign a_mag = A[31] ? -A : A;
  assign b_mag = B[31] ? -B : B;
  assign den_s = b_nz ? b_mag : 32'd1;
  assign den_u = b_nz ? B : 32'd1;
  assign q_mag = a_mag / den_s;
  assign r_mag = a_mag % den_s;
  assign q_s   = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign r_s   = A[31] ? -r_mag : r_mag;
  assign q_u   = A / den_u;
  assign r_u   = A % den_u;

  assign Busy = (Start & ~MDOp[2]) | (state == BUSY);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    p_hi_d  = p_hi;
    p_lo_d  = p_lo;
    p_vld_d = p_vld;
    hi_d    = HI;
    lo_d    = LO;
    if (state == IDLE) begin
      if (Start) begin
        if (!MDOp[2]) begin
          state_d = BUSY;
          cnt_d   = MDOp[1] ? DIV_N : MULT_N;
          // Divide by zero runs the full latency but never commits.
          p_vld_d = ~MDOp[1] | b_nz;
          case (MDOp[1:0])
            2'd0:    {p_hi_d, p_lo_d} = prod_s;
            2'd1:    {p_hi_d, p_lo_d} = prod_u;
            2'd2:    {p_hi_d, p_lo_d} = {r_s, q_s};
            default: {p_hi_d, p_lo_d} = {r_u, q_u};
          endcase
        end else if (MDOp == 3'd4) begin
          hi_d = A;
        end else if (MDOp == 3'd5) begin
          lo_d = A;
        end
      end
    end else begin
      cnt_d = cnt - 5'd1;
      if (cnt == 5'd1) begin
        state_d = IDLE;
        if (p_vld) begin
          hi_d = p_hi;
          lo_d = p_lo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_vld <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      p_hi  <= p_hi_d;
      p_lo  <= p_lo_d;
      p_vld <= p_vld_d;
      HI    <= hi_d;
      LO    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at launch, popped at commit.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start, Busy;
  logic [2:0]  MDOp;
  logic [31:0] A, B, HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb_q[$];
  res_t        r;
  logic [31:0] exp_hi, exp_lo;
  int          errors = 0;
  int          checks = 0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ch, input logic [31:0] cl);
    longint sa, sb, ua, ub, p, q, rm;
    res_t   res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    res.hi = ch;
    res.lo = cl;
    case (op)
      3'd0: begin p = sa * sb; res.hi = p[63:32]; res.lo = p[31:0]; end
      3'd1: begin p = ua * ub; res.hi = p[63:32]; res.lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; rm = sa % sb; res.hi = rm[31:0]; res.lo = q[31:0]; end
      3'd3: if (b != 0) begin q = ua / ub; rm = ua % ub; res.hi = rm[31:0]; res.lo = q[31:0]; end
      default: ;
    endcase
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    sb_q.push_back(model(op, a, b, exp_hi, exp_lo));
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDOp = 3'd7; A = '0; B = '0;
    step(); step();
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    exp_hi = '0; exp_lo = '0;
    reset = 1'b0;
  endtask

  task automatic test_mult_basic();
    launch(3'd0, 32'd7, 32'd6);
    #1;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mult_busy_launch got=%b exp=1", Busy); end
    step(); Start = 1'b0;
    for (int i = 0; i < MC; i++) begin
      #1;
      checks++;
      if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
        errors++; $display("FAIL mult_window cyc=%0d busy=%b hi=%h lo=%h exp busy=1 hi=%h lo=%h", i, Busy, HI, LO, exp_hi, exp_lo);
      end
      step();
    end
    #1;
    r = sb_q.pop_front();
    checks++;
    if (Busy !== 1'b0 || HI !== r.hi || LO !== r.lo || LO !== 32'd42) begin
      errors++; $display("FAIL mult_commit busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", Busy, HI, LO, r.hi, r.lo);
    end
    exp_hi = r.hi; exp_lo = r.lo;
  endtask

  // Shared by mult-sign and divide tables: launch, watch the busy window, check the commit.
  task automatic test_ops(input string name, input logic [2:0] ops[3], input logic [31:0] as[3],
                          input logic [31:0] bs[3], input int n);
    for (int t = 0; t < n; t++) begin
      int lat;
      lat = ops[t][1] ? DC : MC;
      launch(ops[t], as[t], bs[t]);
      step(); Start = 1'b0;
      for (int i = 0; i < lat; i++) begin
        #1;
        checks++;
        if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
          errors++; $display("FAIL %s_window op=%0d cyc=%0d busy=%b hi=%h lo=%h exp hi=%h lo=%h", name, t, i, Busy, HI, LO, exp_hi, exp_lo);
        end
        step();
      end
      #1;
      r = sb_q.pop_front();
      checks++;
      if (Busy !== 1'b0 || HI !== r.hi || LO !== r.lo) begin
        errors++; $display("FAIL %s_commit op=%0d busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", name, t, Busy, HI, LO, r.hi, r.lo);
      end
      exp_hi = r.hi; exp_lo = r.lo;
    end
  endtask

  task automatic test_mult_signs();
    logic [2:0]  ops[3] = '{3'd0, 3'd1, 3'd7};
    logic [31:0] as[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] bs[3]  = '{32'd2, 32'd2, 32'd0};
    test_ops("mult", ops, as, bs, 2);
    checks++; if (HI !== 32'h1 || LO !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_const hi=%h lo=%h exp hi=00000001 lo=fffffffe", HI, LO); end
  endtask

  task automatic test_div();
    logic [2:0]  ops[3] = '{3'd2, 3'd3, 3'd2};
    logic [31:0] as[3]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] bs[3]  = '{32'd2, 32'd2, 32'hFFFFFFFF};
    test_ops("div", ops, as, bs, 3);
    checks++; if (HI !== 32'h0 || LO !== 32'h80000000) begin errors++; $display("FAIL div_overflow hi=%h lo=%h exp hi=0 lo=80000000", HI, LO); end
  endtask

  task automatic test_move_divzero();
    Start = 1'b1; MDOp = 3'd4; A = 32'h12345678; B = 32'd0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
    step();
    exp_hi = 32'h12345678;
    checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("FAIL mthi hi=%h lo=%h exp hi=%h lo=%h", HI, LO, exp_hi, exp_lo); end
    MDOp = 3'd5; A = 32'h9ABCDEF0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%b exp=0", Busy); end
    step();
    exp_lo = 32'h9ABCDEF0;
    checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("FAIL mtlo hi=%h lo=%h exp hi=%h lo=%h", HI, LO, exp_hi, exp_lo); end
    // no-op opcodes must leave everything alone
    MDOp = 3'd6; A = 32'hDEADBEEF;
    step();
    MDOp = 3'd7;
    #1;
    checks++; if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin errors++; $display("FAIL noop busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", Busy, HI, LO, exp_hi, exp_lo); end
    step();
    launch(3'd2, 32'd5, 32'd0);
    step(); Start = 1'b0;
    for (int i = 0; i < DC; i++) begin
      #1;
      checks++;
      if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
        errors++; $display("FAIL divzero_window cyc=%0d busy=%b hi=%h lo=%h", i, Busy, HI, LO);
      end
      step();
    end
    #1;
    r = sb_q.pop_front();
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h12345678 || LO !== 32'h9ABCDEF0 || HI !== r.hi || LO !== r.lo) begin
      errors++; $display("FAIL divzero_commit busy=%b hi=%h lo=%h exp busy=0 hi=12345678 lo=9abcdef0", Busy, HI, LO);
    end
  endtask

  task automatic test_ignore_busy();
    launch(3'd2, 32'd100, 32'd7);
    step(); Start = 1'b0;
    for (int i = 0; i < DC; i++) begin
      if (i == 2) begin Start = 1'b1; MDOp = 3'd0; A = 32'd9; B = 32'd9; end
      else if (i == 3) begin Start = 1'b1; MDOp = 3'd4; A = 32'hCAFEF00D; end
      else Start = 1'b0;
      #1;
      checks++;
      if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
        errors++; $display("FAIL ignore_window cyc=%0d busy=%b hi=%h lo=%h exp hi=%h lo=%h", i, Busy, HI, LO, exp_hi, exp_lo);
      end
      step();
    end
    Start = 1'b0;
    #1;
    r = sb_q.pop_front();
    checks++;
    if (Busy !== 1'b0 || HI !== r.hi || LO !== r.lo || LO !== 32'd14 || HI !== 32'd2) begin
      errors++; $display("FAIL ignore_commit busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", Busy, HI, LO, r.hi, r.lo);
    end
    exp_hi = r.hi; exp_lo = r.lo;
  endtask

  task automatic test_reset_abort();
    launch(3'd0, 32'd3, 32'd3);
    step(); Start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(sb_q.pop_front());
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL abort_reset busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, HI, LO);
    end
    for (int i = 0; i < MC + 2; i++) begin
      step();
      checks++;
      if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
        errors++; $display("FAIL abort_nocommit cyc=%0d busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", i, Busy, HI, LO);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_signs();
    test_div();
    test_move_divzero();
    test_ignore_busy();
    test_reset_abort();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
